// File: rtl/ret_check_pkg.sv
// Shared types and defaults for the return-prediction checker.
// Queue entries pair a RAS prediction-valid flag with the predicted address.
package ret_check_pkg;

   localparam int ADDR_WIDTH      = 32;
   localparam int RET_QUEUE_DEPTH = 8;
   localparam int CNT_WIDTH       = 16;

   typedef struct packed {
      logic                  pv;
      logic [ADDR_WIDTH-1:0] addr;
   } ret_q_entry_t;

   typedef enum logic [1:0] {
      CMP_NONE,
      CMP_HIT,
      CMP_MISS,
      CMP_UNDERFLOW
   } cmp_result_e;

endpackage

// File: rtl/ret_q.sv
// Circular FIFO of in-flight return predictions with simultaneous push/pop and clear.
// The occupancy counter is the only source of full/empty.
module ret_q #(
   parameter int W     = 33,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     clear,
   input  logic [W-1:0]             wr_data,
   output logic [W-1:0]             rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [W-1:0]  mem [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic          do_push;
   logic          do_pop;

   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));

   // A pop at full frees the head slot, so the same-cycle push is admitted.
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);

   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset || clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         // Power-of-2 depth lets the pointers wrap DEPTH-1 -> 0 by overflow.
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: storage is not reset; an entry is only read while count marks it valid.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wr_data;
   end

endmodule

// File: rtl/ret_check.sv
// Return-prediction checker: queues RAS predictions at fetch, compares them with the
// actual target at in-order commit, and pulses mispred with the correct redirect address.
module ret_check
   import ret_check_pkg::*;
#(
   parameter int ADDR  = ADDR_WIDTH,
   parameter int DEPTH = RET_QUEUE_DEPTH,
   parameter int CNT   = CNT_WIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     fetch_ret,
   input  logic                     pred_v,
   input  logic [ADDR-1:0]          pred_addr,
   input  logic                     commit_ret,
   input  logic [ADDR-1:0]          commit_target,
   input  logic                     flush,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     mispred,
   output logic [ADDR-1:0]          redirect_addr,
   output logic [CNT-1:0]           hit_cnt,
   output logic [CNT-1:0]           miss_cnt,
   output logic                     err_ovf,
   output logic                     err_udf
);

   localparam int EW = ADDR + 1;

   logic [EW-1:0]   head;
   logic            head_pv;
   logic [ADDR-1:0] head_addr;
   logic            empty;
   logic            q_push;
   logic            overflow;
   cmp_result_e     cmp;

   // A flushed fetch is younger than the flush and is discarded outright.
   assign q_push   = fetch_ret && !flush;
   assign overflow = q_push && full && !commit_ret;

   ret_q #(
      .W     (EW),
      .DEPTH (DEPTH)
   ) u_ret_q (
      .clk     (clk),
      .reset   (reset),
      .push    (q_push),
      .pop     (commit_ret),
      .clear   (flush),
      .wr_data ({pred_v, pred_addr}),
      .rd_data (head),
      .count   (count),
      .full    (full),
      .empty   (empty)
   );

   assign head_pv   = head[ADDR];
   assign head_addr = head[ADDR-1:0];

   // The committing return is older than any flush, so it is judged against the head as-is.
   // NOTE: every combinational output gets a default first so no latch is inferred.
   always_comb begin
      cmp = CMP_NONE;
      if (commit_ret) begin
         if (empty)
            cmp = CMP_UNDERFLOW;
         else if (head_pv && (head_addr == commit_target))
            cmp = CMP_HIT;
         else
            cmp = CMP_MISS;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (reset) begin
         mispred       <= 1'b0;
         redirect_addr <= '0;
         hit_cnt       <= '0;
         miss_cnt      <= '0;
         err_ovf       <= 1'b0;
         err_udf       <= 1'b0;
      end else begin
         mispred <= (cmp == CMP_MISS) || (cmp == CMP_UNDERFLOW);
         if ((cmp == CMP_MISS) || (cmp == CMP_UNDERFLOW)) begin
            redirect_addr <= commit_target;
            miss_cnt      <= (&miss_cnt) ? miss_cnt : miss_cnt + 1'b1;
         end
         if (cmp == CMP_HIT)
            hit_cnt <= (&hit_cnt) ? hit_cnt : hit_cnt + 1'b1;
         if (cmp == CMP_UNDERFLOW)
            err_udf <= 1'b1;
         if (overflow)
            err_ovf <= 1'b1;
      end
   end

endmodule
